// File: rtl/device_bus_ctrl.sv
// device_bus_ctrl: memory-mapped LED register, 7-segment scanner, free-running SYSTICK and optional timer.
// The timer (TH/TL/TCON and irq) is built only when the macro DEVICE_TIMER_EN is defined;
// otherwise those registers read 0, ignore writes and irq is tied low.
module device_bus_ctrl #(
   parameter int LED_WIDTH  = 8,
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           Address,
   input  logic [31:0]           Write_data,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   output logic [31:0]           Read_data,
   output logic [LED_WIDTH-1:0]  leds,
   output logic [NUM_DIGITS-1:0] digit_an,
   output logic [6:0]            digit_seg,
   output logic                  irq
);
   localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
   localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
   localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
   localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
   localparam logic [31:0] ADDR_DIGI    = 32'h4000_0010;
   localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;
   localparam int DW = $clog2(SCAN_DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

   logic [LED_WIDTH-1:0]    led_q;
   logic [4*NUM_DIGITS-1:0] digi_q;
   logic [4*NUM_DIGITS-1:0] digi_sh;
   logic [31:0]             systick_q;
   logic [DW-1:0]           div_q;
   logic [IW-1:0]           idx_q;
   logic [3:0]              nib;
   logic [31:0]             timer_rd;
   logic [31:0]             rd;
   logic                    we_led;
   logic                    we_digi;
   logic                    unused_wdata;

   assign we_led       = MemWrite && Address == ADDR_LED;
   assign we_digi      = MemWrite && Address == ADDR_DIGI;
   assign unused_wdata = ^Write_data;

`ifdef DEVICE_TIMER_EN
   logic [31:0] th_q;
   logic [31:0] tl_q;
   logic [2:0]  tcon_q;
   logic        we_th;
   logic        we_tl;
   logic        we_tcon;
   logic        ovf;

   assign we_th   = MemWrite && Address == ADDR_TH;
   assign we_tl   = MemWrite && Address == ADDR_TL;
   assign we_tcon = MemWrite && Address == ADDR_TCON;
   assign ovf     = tcon_q[0] && tl_q == 32'hFFFF_FFFF;

   // Timer: bus writes to TL or TCON win over counting, reload and status set in the same cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_q   <= '0;
         tl_q   <= '0;
         tcon_q <= '0;
      end else begin
         if (we_th) th_q <= Write_data;
         if (we_tl) tl_q <= Write_data;
         else if (tcon_q[0]) tl_q <= ovf ? th_q : tl_q + 32'd1;
         if (we_tcon) tcon_q <= Write_data[2:0];
         else if (ovf && tcon_q[1] && !we_tl) tcon_q[2] <= 1'b1;
      end
   end

   assign irq = tcon_q[1] & tcon_q[2];

   // Timer register read-back, zero when the address is not a timer register
   always_comb begin
      timer_rd = '0;
      if (Address == ADDR_TH) timer_rd = th_q;
      else if (Address == ADDR_TL) timer_rd = tl_q;
      else if (Address == ADDR_TCON) timer_rd = 32'(tcon_q);
   end
`else
   assign irq      = 1'b0;
   assign timer_rd = '0;
`endif

   // LED and DIGI registers, upper write-data bits dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q  <= '0;
         digi_q <= '0;
      end else begin
         if (we_led) led_q <= Write_data[LED_WIDTH-1:0];
         if (we_digi) digi_q <= Write_data[4*NUM_DIGITS-1:0];
      end
   end

   // Free-running cycle counter, wraps naturally at 2^32
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) systick_q <= '0;
      else systick_q <= systick_q + 32'd1;
   end

   // Scan divider and digit index; DIGI writes never touch these
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q <= '0;
         idx_q <= '0;
      end else if (div_q == DW'(SCAN_DIV - 1)) begin
         div_q <= '0;
         idx_q <= idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
      end else begin
         div_q <= div_q + DW'(1);
      end
   end

   assign leds     = led_q;
   assign digit_an = ~(NUM_DIGITS'(1) << idx_q);
   assign digi_sh  = digi_q >> {idx_q, 2'b00};
   assign nib      = digi_sh[3:0];

   // Hex to active-low {g,f,e,d,c,b,a}
   always_comb begin
      case (nib)
         4'h0:    digit_seg = 7'b1000000;
         4'h1:    digit_seg = 7'b1111001;
         4'h2:    digit_seg = 7'b0100100;
         4'h3:    digit_seg = 7'b0110000;
         4'h4:    digit_seg = 7'b0011001;
         4'h5:    digit_seg = 7'b0010010;
         4'h6:    digit_seg = 7'b0000010;
         4'h7:    digit_seg = 7'b1111000;
         4'h8:    digit_seg = 7'b0000000;
         4'h9:    digit_seg = 7'b0010000;
         4'hA:    digit_seg = 7'b0001000;
         4'hB:    digit_seg = 7'b0000011;
         4'hC:    digit_seg = 7'b1000110;
         4'hD:    digit_seg = 7'b0100001;
         4'hE:    digit_seg = 7'b0000110;
         default: digit_seg = 7'b0001110;
      endcase
   end

   // Combinational load data, zero unless MemRead and a mapped address
   always_comb begin
      rd = timer_rd;
      if (Address == ADDR_LED) rd = 32'(led_q);
      else if (Address == ADDR_DIGI) rd = 32'(digi_q);
      else if (Address == ADDR_SYSTICK) rd = systick_q;
      Read_data = MemRead ? rd : '0;
   end
endmodule

// File: tb/tb_device_bus_ctrl.sv
// tb_device_bus_ctrl: randomized self-checking bench for device_bus_ctrl against a cycle-count model.
module tb_device_bus_ctrl;
   localparam int LW = 8;
   localparam int ND = 4;
   localparam int SD = 4;
   localparam logic [31:0] A_TH = 32'h40000000, A_TL = 32'h40000004, A_TCON = 32'h40000008;
   localparam logic [31:0] A_LED = 32'h4000000C, A_DIGI = 32'h40000010, A_TICK = 32'h40000014;

   logic clk = 0, reset = 0, MemRead = 0, MemWrite = 0;
   logic [31:0] Address = 0, Write_data = 0, Read_data;
   logic [LW-1:0] leds;
   logic [ND-1:0] digit_an;
   logic [6:0] digit_seg;
   logic irq;
   int checks = 0, failures = 0;

   logic [7:0] m_led;
   logic [15:0] m_digi;
   logic [31:0] m_tick, m_th, m_tl;
   logic [2:0] m_tcon;
   int unsigned m_scan;
   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   device_bus_ctrl #(.LED_WIDTH(LW), .NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
      .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
      .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data),
      .leds(leds), .digit_an(digit_an), .digit_seg(digit_seg), .irq(irq));

   always #5 clk = ~clk;

   task automatic model_reset();
      m_led = 0; m_digi = 0; m_tick = 0; m_th = 0; m_tl = 0; m_tcon = 0; m_scan = 0;
   endtask

   function automatic int cur_digit();
      return (m_scan / SD) % ND;
   endfunction

   function automatic logic [ND-1:0] exp_an();
      return ~(ND'(1) << cur_digit());
   endfunction

   function automatic logic [6:0] exp_seg();
      return seg_tab[4'(m_digi >> (4 * cur_digit()))];
   endfunction

   function automatic logic exp_irq();
`ifdef DEVICE_TIMER_EN
      return m_tcon[1] & m_tcon[2];
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] mread(input logic [31:0] a);
      if (a == A_LED) return {24'b0, m_led};
      if (a == A_DIGI) return {16'b0, m_digi};
      if (a == A_TICK) return m_tick;
`ifdef DEVICE_TIMER_EN
      if (a == A_TH) return m_th;
      if (a == A_TL) return m_tl;
      if (a == A_TCON) return {29'b0, m_tcon};
`endif
      return 32'b0;
   endfunction

   // One clock edge; the model applies the register-map rules to the inputs seen at that edge
   task automatic step();
      logic [31:0] n_tl;
      logic [2:0] n_tc;
      logic wrap;
      @(posedge clk);
      if (reset) begin
         wrap = m_tcon[0] && m_tl == 32'hFFFFFFFF;
         n_tl = !m_tcon[0] ? m_tl : wrap ? m_th : m_tl + 1;
         n_tc = m_tcon;
         if (wrap && m_tcon[1]) n_tc[2] = 1'b1;
         if (MemWrite) begin
            if (Address == A_TL) begin n_tl = Write_data; n_tc = m_tcon; end
            if (Address == A_TCON) n_tc = Write_data[2:0];
            if (Address == A_TH) m_th = Write_data;
            if (Address == A_LED) m_led = Write_data[7:0];
            if (Address == A_DIGI) m_digi = Write_data[15:0];
         end
         m_tl = n_tl; m_tcon = n_tc;
         m_tick = m_tick + 1;
         m_scan = m_scan + 1;
      end
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Address = a; Write_data = d; MemWrite = 1;
      step();
      MemWrite = 0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      Address = a; MemRead = 1;
      #1;
      v = Read_data;
      MemRead = 0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 0; model_reset();
      #12;
      checks++; if (leds !== 8'h00) begin failures++; $display("FAIL reset_leds got=%h exp=00", leds); end
      checks++; if (digit_an !== 4'b1110) begin failures++; $display("FAIL reset_an got=%b exp=1110", digit_an); end
      checks++; if (digit_seg !== 7'b1000000) begin failures++; $display("FAIL reset_seg got=%b exp=1000000", digit_seg); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
      rd(A_TICK, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_systick got=%h exp=0", v); end
      @(negedge clk); #2 reset = 1;
   endtask

   task automatic test_led();
      logic [31:0] v, d;
      wr(A_LED, 32'h000000A5);
      checks++; if (leds !== 8'hA5) begin failures++; $display("FAIL led_a5 got=%h exp=a5", leds); end
      rd(A_LED, v);
      checks++; if (v !== 32'h000000A5) begin failures++; $display("FAIL led_read got=%h exp=000000a5", v); end
      rd(32'h40000018, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", v); end
      Address = A_LED; MemRead = 0; #1;
      checks++; if (Read_data !== 32'h0) begin failures++; $display("FAIL no_memread got=%h exp=0", Read_data); end
      repeat (6) begin
         d = $urandom;
         wr(A_LED, d);
         checks++; if (leds !== d[7:0]) begin failures++; $display("FAIL led_rand got=%h exp=%h", leds, d[7:0]); end
         rd(A_LED, v);
         checks++; if (v !== {24'b0, d[7:0]}) begin failures++; $display("FAIL led_rand_read got=%h exp=%h", v, {24'b0, d[7:0]}); end
      end
   endtask

   task automatic test_systick();
      logic [31:0] v, first;
      rd(A_TICK, first);
      checks++; if (first !== m_tick) begin failures++; $display("FAIL systick got=%h exp=%h", first, m_tick); end
      repeat (3) step();
      rd(A_TICK, v);
      checks++; if (v !== first + 3) begin failures++; $display("FAIL systick_delta got=%h exp=%h", v, first + 3); end
      wr(A_TICK, 32'h0);
      rd(A_TICK, v);
      checks++; if (v !== m_tick) begin failures++; $display("FAIL systick_ro got=%h exp=%h", v, m_tick); end
   endtask

   task automatic test_scan();
      logic [31:0] v;
      wr(A_DIGI, 32'hFFFF1234);
      rd(A_DIGI, v);
      checks++; if (v !== 32'h00001234) begin failures++; $display("FAIL digi_read got=%h exp=00001234", v); end
      repeat (20) begin
         step();
         checks++; if (digit_an !== exp_an()) begin failures++; $display("FAIL scan_an got=%b exp=%b", digit_an, exp_an()); end
         checks++; if (digit_seg !== exp_seg()) begin failures++; $display("FAIL scan_seg got=%b exp=%b", digit_seg, exp_seg()); end
      end
      repeat (12) begin
         wr(A_DIGI, $urandom);
         checks++; if (digit_an !== exp_an()) begin failures++; $display("FAIL digi_wr_an got=%b exp=%b", digit_an, exp_an()); end
         checks++; if (digit_seg !== exp_seg()) begin failures++; $display("FAIL digi_wr_seg got=%b exp=%b", digit_seg, exp_seg()); end
      end
   endtask

`ifdef DEVICE_TIMER_EN
   task automatic test_timer();
      logic [31:0] v;
      wr(A_TH, 32'hFFFFFFFC);
      wr(A_TL, 32'hFFFFFFFE);
      wr(A_TCON, 32'h3);
      step(); step();
      rd(A_TL, v);
      checks++; if (v !== 32'hFFFFFFFC) begin failures++; $display("FAIL tl_reload got=%h exp=fffffffc", v); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
      rd(A_TCON, v);
      checks++; if (v !== 32'h7) begin failures++; $display("FAIL tcon_status got=%h exp=7", v); end
      wr(A_TCON, 32'h3);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
      wr(A_TL, 32'hFFFFFFFF);
      wr(A_TL, 32'h10);
      rd(A_TL, v);
      checks++; if (v !== 32'h10) begin failures++; $display("FAIL tl_write_prio got=%h exp=10", v); end
      rd(A_TCON, v);
      checks++; if (v !== 32'h3) begin failures++; $display("FAIL no_status_on_write got=%h exp=3", v); end
      step();
      rd(A_TL, v);
      checks++; if (v !== 32'h11) begin failures++; $display("FAIL tl_count got=%h exp=11", v); end
      wr(A_TL, 32'hFFFFFFFF);
      wr(A_TCON, 32'h3);
      rd(A_TL, v);
      checks++; if (v !== m_tl) begin failures++; $display("FAIL tcon_wr_reload got=%h exp=%h", v, m_tl); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL tcon_wr_irq got=%b exp=0", irq); end
      wr(A_TCON, 32'h0);
      step(); step();
      rd(A_TL, v);
      checks++; if (v !== m_tl) begin failures++; $display("FAIL tl_hold got=%h exp=%h", v, m_tl); end
   endtask
`else
   task automatic test_no_timer();
      logic [31:0] v;
      wr(A_TCON, 32'h7);
      wr(A_TH, 32'h12345678);
      wr(A_TL, 32'hFFFFFFFF);
      rd(A_TCON, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL tcon_absent got=%h exp=0", v); end
      rd(A_TH, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL th_absent got=%h exp=0", v); end
      rd(A_TL, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL tl_absent got=%h exp=0", v); end
      repeat (4) begin
         step();
         checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_absent got=%b exp=0", irq); end
      end
   endtask
`endif

   task automatic test_random();
      logic [31:0] a, d, v;
      int unsigned r;
      repeat (300) begin
         r = $urandom_range(0, 8);
         a = r < 6 ? 32'h40000000 + 32'(4 * r) : r == 6 ? 32'h40000018 : r == 7 ? 32'h40000001 : $urandom;
         d = $urandom_range(0, 1) ? (32'hFFFFFFF8 | 32'($urandom_range(0, 7))) : $urandom;
         if ($urandom_range(0, 2) == 0) step(); else wr(a, d);
         checks++; if (leds !== m_led) begin failures++; $display("FAIL rnd_leds got=%h exp=%h", leds, m_led); end
         checks++; if (digit_an !== exp_an()) begin failures++; $display("FAIL rnd_an got=%b exp=%b", digit_an, exp_an()); end
         checks++; if (digit_seg !== exp_seg()) begin failures++; $display("FAIL rnd_seg got=%b exp=%b", digit_seg, exp_seg()); end
         checks++; if (irq !== exp_irq()) begin failures++; $display("FAIL rnd_irq got=%b exp=%b", irq, exp_irq()); end
         r = $urandom_range(0, 7);
         a = r < 6 ? 32'h40000000 + 32'(4 * r) : r == 6 ? 32'h40000018 : $urandom;
         rd(a, v);
         checks++; if (v !== mread(a)) begin failures++; $display("FAIL rnd_read addr=%h got=%h exp=%h", a, v, mread(a)); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      wr(A_LED, 32'h5A);
      wr(A_DIGI, 32'h9876);
`ifdef DEVICE_TIMER_EN
      wr(A_TH, 32'h0);
      wr(A_TL, 32'hFFFFFFFD);
      wr(A_TCON, 32'h3);
      repeat (3) step();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
`else
      repeat (3) step();
`endif
      #2 reset = 0;
      #1;
      checks++; if (digit_an !== 4'b1110) begin failures++; $display("FAIL mid_reset_an got=%b exp=1110", digit_an); end
      checks++; if (digit_seg !== 7'b1000000) begin failures++; $display("FAIL mid_reset_seg got=%b exp=1000000", digit_seg); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_reset_irq got=%b exp=0", irq); end
      checks++; if (leds !== 8'h00) begin failures++; $display("FAIL mid_reset_leds got=%h exp=00", leds); end
      model_reset();
      @(posedge clk);
      #2;
      rd(A_DIGI, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL mid_reset_digi got=%h exp=0", v); end
      rd(A_TL, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL mid_reset_tl got=%h exp=0", v); end
      rd(A_TICK, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL mid_reset_tick got=%h exp=0", v); end
      reset = 1;
      repeat (3) step();
      rd(A_TICK, v);
      checks++; if (v !== 32'h3) begin failures++; $display("FAIL tick_restart got=%h exp=3", v); end
      checks++; if (digit_an !== exp_an()) begin failures++; $display("FAIL scan_restart got=%b exp=%b", digit_an, exp_an()); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL timer_abandoned got=%b exp=0", irq); end
   endtask

   initial begin
      test_reset();
      test_led();
      test_systick();
      test_scan();
`ifdef DEVICE_TIMER_EN
      test_timer();
`else
      test_no_timer();
`endif
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
